// File: rtl/uart_defines.sv
// Shared encodings for the UART transmit path: parity modes and FSM states.
package uart_defines;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 868,
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    output logic          tick,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    assign tick = enable && !clear && (count == LAST);

    // Free-running within a bit; wraps to zero so the next bit starts cleanly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a show-ahead FIFO; back-to-back frames with no idle gap.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | line high, waiting for enable and a queued word
// ST_START  | start bit (low)
// ST_DATA   | data bits, LSB first
// ST_PARITY | optional parity bit
// ST_STOP   | stop bit(s) high; decides next frame or idle
module fifo_uart_tx
    import uart_defines::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_stb,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_byte_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_PRE_LAST = CW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] BIT_LAST     = BW'(DATA_WIDTH - 1);
    localparam logic          STOP_LAST    = (STOP_BITS > 1);
    localparam logic          HAS_PARITY   = (PARITY != PARITY_NONE);
    localparam logic          ODD_PARITY   = (PARITY == PARITY_ODD);

    tx_state_t             state, state_n;
    logic [DATA_WIDTH-1:0] shift_q, shift_n;
    logic [BW-1:0]         bit_q, bit_n;
    logic                  par_q, par_n;
    logic                  stop_q, stop_n;
    logic                  tx_n, stb_n, busy_n, done_n;
    logic                  load;
    logic                  baud_tick;
    logic [CW-1:0]         baud_cnt;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (state == ST_IDLE),
        .enable(state != ST_IDLE),
        .tick  (baud_tick),
        .count (baud_cnt)
    );

    // Next-state and next-output decode; outputs are computed one cycle ahead so they leave flops.
    always_comb begin
        state_n = state;
        shift_n = shift_q;
        bit_n   = bit_q;
        par_n   = par_q;
        stop_n  = stop_q;
        tx_n    = o_tx;
        stb_n   = 1'b0;
        busy_n  = o_busy;
        done_n  = 1'b0;
        load    = 1'b0;

        case (state)
            ST_IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                load   = i_enable && !i_fifo_empty;
            end
            ST_START: begin
                if (baud_tick) begin
                    state_n = ST_DATA;
                    bit_n   = '0;
                    tx_n    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    par_n = par_q ^ shift_q[0];
                    if (bit_q == BIT_LAST) begin
                        if (HAS_PARITY) begin
                            state_n = ST_PARITY;
                            tx_n    = par_q ^ shift_q[0];
                        end else begin
                            state_n = ST_STOP;
                            stop_n  = 1'b0;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_n   = bit_q + 1'b1;
                        shift_n = shift_q >> 1;
                        tx_n    = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    state_n = ST_STOP;
                    stop_n  = 1'b0;
                    tx_n    = 1'b1;
                end
            end
            ST_STOP: begin
                // Next cycle is the very last cycle of the frame.
                if (stop_q == STOP_LAST && baud_cnt == CNT_PRE_LAST) begin
                    done_n = 1'b1;
                end
                if (baud_tick) begin
                    if (stop_q != STOP_LAST) begin
                        stop_n = 1'b1;
                    end else if (i_enable && !i_fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                        tx_n    = 1'b1;
                        busy_n  = 1'b0;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Word is captured on the same edge that raises the pop strobe, so the head is never stale.
        if (load) begin
            state_n = ST_START;
            shift_n = i_fifo_data;
            par_n   = ODD_PARITY;
            bit_n   = '0;
            stop_n  = 1'b0;
            tx_n    = 1'b0;
            stb_n   = 1'b1;
            busy_n  = 1'b1;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            shift_q     <= '0;
            bit_q       <= '0;
            par_q       <= 1'b0;
            stop_q      <= 1'b0;
            o_tx        <= 1'b1;
            o_fifo_stb  <= 1'b0;
            o_busy      <= 1'b0;
            o_byte_done <= 1'b0;
        end else begin
            state       <= state_n;
            shift_q     <= shift_n;
            bit_q       <= bit_n;
            par_q       <= par_n;
            stop_q      <= stop_n;
            o_tx        <= tx_n;
            o_fifo_stb  <= stb_n;
            o_busy      <= busy_n;
            o_byte_done <= done_n;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three configurations (8N1, 8E1, 8O2) fed by a show-ahead FIFO model,
// compared against a frame-level model (bit list expanded to CLKS_PER_BIT cycles per bit).
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk     = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst     = 1'b0;
    logic       en      [3];
    logic       empty_r [3];
    logic [7:0] data_r  [3];
    logic       tx_w    [3];
    logic       stb_w   [3];
    logic       busy_w  [3];
    logic       done_w  [3];

    int d_par  [3] = '{0, 1, 2};
    int d_stop [3] = '{1, 1, 2};

    logic [7:0] fq     [3][$];
    logic       e_tx   [3][$];
    logic       e_stb  [3][$];
    logic       e_busy [3][$];
    logic       e_done [3][$];
    logic       s_tx [3], s_stb [3], s_busy [3], s_done [3];
    logic       prev_stb [3];

    int errors = 0;
    int checks = 0;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1)) dut_n (
        .clk(clk), .rst(rst), .i_enable(en[0]), .i_fifo_data(data_r[0]), .i_fifo_empty(empty_r[0]),
        .o_fifo_stb(stb_w[0]), .o_tx(tx_w[0]), .o_busy(busy_w[0]), .o_byte_done(done_w[0]));

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY(1), .STOP_BITS(1)) dut_e (
        .clk(clk), .rst(rst), .i_enable(en[1]), .i_fifo_data(data_r[1]), .i_fifo_empty(empty_r[1]),
        .o_fifo_stb(stb_w[1]), .o_tx(tx_w[1]), .o_busy(busy_w[1]), .o_byte_done(done_w[1]));

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY(2), .STOP_BITS(2)) dut_o (
        .clk(clk), .rst(rst), .i_enable(en[2]), .i_fifo_data(data_r[2]), .i_fifo_empty(empty_r[2]),
        .o_fifo_stb(stb_w[2]), .o_tx(tx_w[2]), .o_busy(busy_w[2]), .o_byte_done(done_w[2]));

    always #5 if (clk_run) clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic void refresh(int d);
        empty_r[d] = (fq[d].size() == 0);
        data_r[d]  = (fq[d].size() > 0) ? fq[d][0] : 8'h00;
    endfunction

    task automatic push(int d, logic [7:0] w);
        fq[d].push_back(w);
        refresh(d);
    endtask

    // One clock: FIFO pops on the edge that ends a strobe cycle, then outputs are sampled.
    task automatic step();
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            if (prev_stb[d] && fq[d].size() > 0) void'(fq[d].pop_front());
            refresh(d);
            s_tx[d]     = tx_w[d];
            s_stb[d]    = stb_w[d];
            s_busy[d]   = busy_w[d];
            s_done[d]   = done_w[d];
            prev_stb[d] = stb_w[d];
        end
    endtask

    // Reference frame: start, data LSB first, optional parity, stop bits; each bit held CPB cycles.
    function automatic void add_frame(int d, logic [7:0] w);
        logic bits [$];
        int   n;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(w[i]);
        if (d_par[d] == 1) bits.push_back(^w);
        if (d_par[d] == 2) bits.push_back(~^w);
        for (int s = 0; s < d_stop[d]; s++) bits.push_back(1'b1);
        n = bits.size() * CPB;
        for (int k = 0; k < n; k++) begin
            e_tx[d].push_back(bits[k / CPB]);
            e_stb[d].push_back(k == 0);
            e_busy[d].push_back(1'b1);
            e_done[d].push_back(k == n - 1);
        end
    endfunction

    function automatic void clear_exp();
        for (int d = 0; d < 3; d++) begin
            e_tx[d].delete();
            e_stb[d].delete();
            e_busy[d].delete();
            e_done[d].delete();
        end
    endfunction

    function automatic logic ex_tx(int d, int k);
        if (k < e_tx[d].size()) return e_tx[d][k];
        return 1'b1;
    endfunction
    function automatic logic ex_stb(int d, int k);
        if (k < e_stb[d].size()) return e_stb[d][k];
        return 1'b0;
    endfunction
    function automatic logic ex_busy(int d, int k);
        if (k < e_busy[d].size()) return e_busy[d][k];
        return 1'b0;
    endfunction
    function automatic logic ex_done(int d, int k);
        if (k < e_done[d].size()) return e_done[d][k];
        return 1'b0;
    endfunction

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (tx_w[d] !== 1'b1) begin errors++; $display("FAIL reset_tx dut%0d: got %b want 1", d, tx_w[d]); end
            checks++;
            if (stb_w[d] !== 1'b0) begin errors++; $display("FAIL reset_stb dut%0d: got %b want 0", d, stb_w[d]); end
            checks++;
            if (busy_w[d] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d: got %b want 0", d, busy_w[d]); end
            checks++;
            if (done_w[d] !== 1'b0) begin errors++; $display("FAIL reset_done dut%0d: got %b want 0", d, done_w[d]); end
        end
        clk_run = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        int mt = 0, mb = 0, md = 0, nstb = 0, done_at = -1;
        logic [9:0] obs = '0;
        clear_exp();
        add_frame(0, 8'hA5);
        en[0] = 1'b1;
        push(0, 8'hA5);
        for (int k = 0; k < 45; k++) begin
            step();
            mt += int'(s_tx[0] !== ex_tx(0, k));
            mb += int'(s_busy[0] !== ex_busy(0, k));
            md += int'(s_done[0] !== ex_done(0, k));
            if (s_stb[0]) nstb++;
            if (s_done[0] && done_at < 0) done_at = k + 1;
            if (k < 40 && (k % CPB) == 1) obs[k / CPB] = s_tx[0];
        end
        en[0] = 1'b0;
        checks++;
        if (obs !== 10'b1101001010) begin errors++; $display("FAIL single_bits: got %b want 1101001010", obs); end
        checks++;
        if (mt !== 0) begin errors++; $display("FAIL single_tx_wave: mismatched cycles %0d want 0", mt); end
        checks++;
        if (nstb !== 1) begin errors++; $display("FAIL single_stb_count: got %0d want 1", nstb); end
        checks++;
        if (done_at !== 40) begin errors++; $display("FAIL single_done_cycle: got %0d want 40", done_at); end
        checks++;
        if (md !== 0) begin errors++; $display("FAIL single_done_wave: mismatched cycles %0d want 0", md); end
        checks++;
        if (mb !== 0) begin errors++; $display("FAIL single_busy_wave: mismatched cycles %0d want 0", mb); end
        checks++;
        if (fq[0].size() !== 0) begin errors++; $display("FAIL single_fifo_empty: got %0d words want 0", fq[0].size()); end
    endtask

    task automatic test_back_to_back();
        int mt = 0, mb = 0, nbusy = 0;
        int stb_at [$];
        logic [7:0] words [3] = '{8'h00, 8'hFF, 8'h55};
        clear_exp();
        for (int i = 0; i < 3; i++) begin
            add_frame(0, words[i]);
            push(0, words[i]);
        end
        en[0] = 1'b1;
        for (int k = 0; k < 125; k++) begin
            step();
            mt += int'(s_tx[0] !== ex_tx(0, k));
            mb += int'(s_busy[0] !== ex_busy(0, k));
            if (s_stb[0]) stb_at.push_back(k + 1);
            if (k < 120 && s_busy[0]) nbusy++;
        end
        en[0] = 1'b0;
        checks++;
        if (mt !== 0) begin errors++; $display("FAIL b2b_tx_wave: mismatched cycles %0d want 0", mt); end
        checks++;
        if (mb !== 0) begin errors++; $display("FAIL b2b_busy_wave: mismatched cycles %0d want 0", mb); end
        checks++;
        if (nbusy !== 120) begin errors++; $display("FAIL b2b_busy_span: got %0d want 120", nbusy); end
        checks++;
        if (stb_at.size() !== 3) begin
            errors++; $display("FAIL b2b_pop_count: got %0d want 3", stb_at.size());
        end else begin
            checks++;
            if (stb_at[1] - stb_at[0] !== 40) begin errors++; $display("FAIL b2b_pop_gap1: got %0d want 40", stb_at[1] - stb_at[0]); end
            checks++;
            if (stb_at[2] - stb_at[1] !== 40) begin errors++; $display("FAIL b2b_pop_gap2: got %0d want 40", stb_at[2] - stb_at[1]); end
        end
    endtask

    task automatic test_parity();
        int mt [3] = '{0, 0, 0};
        int done_at [3] = '{-1, -1, -1};
        int stop_hi = 0;
        logic pe = 1'bx, po = 1'bx, busy_after = 1'bx;
        clear_exp();
        add_frame(1, 8'h07);
        add_frame(2, 8'h07);
        en[1] = 1'b1;
        en[2] = 1'b1;
        push(1, 8'h07);
        push(2, 8'h07);
        for (int k = 0; k < 52; k++) begin
            step();
            for (int d = 1; d < 3; d++) begin
                mt[d] += int'(s_tx[d] !== ex_tx(d, k)) + int'(s_stb[d] !== ex_stb(d, k))
                       + int'(s_busy[d] !== ex_busy(d, k)) + int'(s_done[d] !== ex_done(d, k));
                if (s_done[d] && done_at[d] < 0) done_at[d] = k + 1;
            end
            if (k == 38) begin pe = s_tx[1]; po = s_tx[2]; end
            if (k >= 40 && k < 48 && s_tx[2] === 1'b1) stop_hi++;
            if (k == 48) busy_after = s_busy[2];
        end
        en[1] = 1'b0;
        en[2] = 1'b0;
        checks++;
        if (pe !== 1'b1) begin errors++; $display("FAIL parity_even_bit: got %b want 1", pe); end
        checks++;
        if (po !== 1'b0) begin errors++; $display("FAIL parity_odd_bit: got %b want 0", po); end
        checks++;
        if (done_at[1] !== 44) begin errors++; $display("FAIL parity_even_len: got %0d want 44", done_at[1]); end
        checks++;
        if (done_at[2] !== 48) begin errors++; $display("FAIL parity_odd_2stop_len: got %0d want 48", done_at[2]); end
        checks++;
        if (stop_hi !== 8) begin errors++; $display("FAIL parity_stop2_high: got %0d want 8", stop_hi); end
        checks++;
        if (busy_after !== 1'b0) begin errors++; $display("FAIL parity_busy_fall: got %b want 0", busy_after); end
        checks++;
        if (mt[1] !== 0) begin errors++; $display("FAIL parity_even_wave: mismatches %0d want 0", mt[1]); end
        checks++;
        if (mt[2] !== 0) begin errors++; $display("FAIL parity_odd_wave: mismatches %0d want 0", mt[2]); end
    endtask

    task automatic test_enable_gating();
        logic [7:0] w1, w2;
        int m1 = 0, m2 = 0, gap_stb = 0, gap_act = 0;
        logic first_stb = 1'b0, first_tx = 1'b1;
        w1 = 8'($urandom);
        w2 = 8'($urandom);
        clear_exp();
        add_frame(0, w1);
        push(0, w1);
        push(0, w2);
        en[0] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (k == 17) en[0] = 1'b0;
            m1 += int'(s_tx[0] !== ex_tx(0, k)) + int'(s_stb[0] !== ex_stb(0, k))
                + int'(s_busy[0] !== ex_busy(0, k)) + int'(s_done[0] !== ex_done(0, k));
        end
        for (int k = 0; k < 20; k++) begin
            step();
            if (s_stb[0]) gap_stb++;
            if (s_busy[0] || !s_tx[0]) gap_act++;
        end
        checks++;
        if (fq[0].size() !== 1) begin errors++; $display("FAIL gate_queue_left: got %0d want 1", fq[0].size()); end
        en[0] = 1'b1;
        clear_exp();
        add_frame(0, w2);
        for (int k = 0; k < 44; k++) begin
            step();
            if (k == 0) begin first_stb = s_stb[0]; first_tx = s_tx[0]; end
            m2 += int'(s_tx[0] !== ex_tx(0, k)) + int'(s_stb[0] !== ex_stb(0, k))
                + int'(s_busy[0] !== ex_busy(0, k)) + int'(s_done[0] !== ex_done(0, k));
        end
        en[0] = 1'b0;
        checks++;
        if (m1 !== 0) begin errors++; $display("FAIL gate_first_frame: mismatches %0d want 0", m1); end
        checks++;
        if (gap_stb !== 0) begin errors++; $display("FAIL gate_no_pop: got %0d strobes want 0", gap_stb); end
        checks++;
        if (gap_act !== 0) begin errors++; $display("FAIL gate_idle_line: got %0d active cycles want 0", gap_act); end
        checks++;
        if (first_stb !== 1'b1 || first_tx !== 1'b0) begin
            errors++; $display("FAIL gate_restart_latency: stb=%b tx=%b want stb=1 tx=0", first_stb, first_tx);
        end
        checks++;
        if (m2 !== 0) begin errors++; $display("FAIL gate_second_frame: mismatches %0d want 0", m2); end
    endtask

    task automatic test_async_reset();
        logic [7:0] w1, w2;
        int m = 0, nstb = 0;
        w1 = 8'($urandom);
        w2 = 8'($urandom);
        push(0, w1);
        push(0, w2);
        en[0] = 1'b1;
        for (int k = 0; k < 10; k++) step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (tx_w[0] !== 1'b1) begin errors++; $display("FAIL areset_tx: got %b want 1", tx_w[0]); end
        checks++;
        if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b want 0", busy_w[0]); end
        checks++;
        if (stb_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
            errors++; $display("FAIL areset_pulses: stb=%b done=%b want 0 0", stb_w[0], done_w[0]);
        end
        step();
        step();
        rst = 1'b0;
        clear_exp();
        add_frame(0, w2);
        for (int k = 0; k < 44; k++) begin
            step();
            m += int'(s_tx[0] !== ex_tx(0, k)) + int'(s_busy[0] !== ex_busy(0, k))
               + int'(s_done[0] !== ex_done(0, k));
            if (s_stb[0]) nstb++;
        end
        en[0] = 1'b0;
        checks++;
        if (m !== 0) begin errors++; $display("FAIL areset_resume_frame: mismatches %0d want 0", m); end
        checks++;
        if (nstb !== 1) begin errors++; $display("FAIL areset_resume_pops: got %0d want 1", nstb); end
        checks++;
        if (fq[0].size() !== 0) begin errors++; $display("FAIL areset_fifo_empty: got %0d want 0", fq[0].size()); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int mt [3] = '{0, 0, 0};
            int ms [3] = '{0, 0, 0};
            int mb [3] = '{0, 0, 0};
            int md [3] = '{0, 0, 0};
            int len = 0;
            clear_exp();
            for (int d = 0; d < 3; d++) begin
                int n;
                n = int'($urandom_range(1, 4));
                for (int i = 0; i < n; i++) begin
                    logic [7:0] w;
                    w = 8'($urandom);
                    add_frame(d, w);
                    push(d, w);
                end
                if (e_tx[d].size() > len) len = e_tx[d].size();
                en[d] = 1'b1;
            end
            for (int k = 0; k < len + 4; k++) begin
                step();
                for (int d = 0; d < 3; d++) begin
                    mt[d] += int'(s_tx[d] !== ex_tx(d, k));
                    ms[d] += int'(s_stb[d] !== ex_stb(d, k));
                    mb[d] += int'(s_busy[d] !== ex_busy(d, k));
                    md[d] += int'(s_done[d] !== ex_done(d, k));
                end
            end
            for (int d = 0; d < 3; d++) begin
                en[d] = 1'b0;
                checks++;
                if (mt[d] !== 0) begin errors++; $display("FAIL rand_tx it%0d dut%0d: mismatches %0d want 0", it, d, mt[d]); end
                checks++;
                if (ms[d] !== 0) begin errors++; $display("FAIL rand_stb it%0d dut%0d: mismatches %0d want 0", it, d, ms[d]); end
                checks++;
                if (mb[d] !== 0) begin errors++; $display("FAIL rand_busy it%0d dut%0d: mismatches %0d want 0", it, d, mb[d]); end
                checks++;
                if (md[d] !== 0) begin errors++; $display("FAIL rand_done it%0d dut%0d: mismatches %0d want 0", it, d, md[d]); end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            en[d]       = 1'b0;
            prev_stb[d] = 1'b0;
            refresh(d);
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_enable_gating();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that drains the generic FIFO's read side and emits its words as asynchronous UART frames. It sits directly downstream of the FIFO and connects to the FIFO's show-ahead read port (data valid whenever not empty; one-cycle strobe pops). The FIFO's read clock and read reset are driven from this block's `clk` and `rst`. Typical use is streaming NES debug/trace bytes out to a host.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit. Minimum is 2.
- `DATA_WIDTH`, default 8: bits per frame. Must equal the FIFO `WIDTH`.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `i_enable`  in  1: permits starting new frames.
- `i_fifo_data`  in  DATA_WIDTH: FIFO head word (show-ahead).
- `i_fifo_empty`  in  1: FIFO empty flag.
- `o_fifo_stb`  out  1: pop strobe, exactly one cycle per frame.
- `o_tx`  out  1: serial line, idles high.
- `o_busy`  out  1: high while a frame is in flight.
- `o_byte_done`  out  1: one-cycle pulse on the last cycle of the final stop bit.

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:**
  - `o_tx` = 1 and `o_busy` = 0.
  - On an edge with `i_enable` && !`i_fifo_empty`:
    - latch `i_fifo_data` into the shift register;
    - set `o_fifo_stb` for one cycle;
    - go to START.
- **START:** `o_tx` = 0 for CLKS_PER_BIT cycles.
- **DATA:**
  - Sends DATA_WIDTH bits, LSB first, each for CLKS_PER_BIT cycles.
  - The bit counter counts 0..DATA_WIDTH-1.
- **PARITY:**
  - Entered only if PARITY != 0.
  - Even parity: the bit is the XOR of the data bits.
  - Odd parity: the bit is the inverted XOR of the data bits.
  - Lasts one bit time.
- **STOP:** `o_tx` = 1 for STOP_BITS*CLKS_PER_BIT cycles.
- **Frame end (last STOP cycle):**
  - `o_byte_done` pulses.
  - If `i_enable` && !`i_fifo_empty`: latch the next word, pop it, and go straight to START, with no idle gap.
  - Otherwise go to IDLE.
- **Baud counter:**
  - Counts 0..CLKS_PER_BIT-1.
  - Resets on every bit transition.
  - Its width is $clog2(CLKS_PER_BIT).
- **`i_enable` low mid-frame:** the current frame completes normally. No new pop occurs until `i_enable` rises again.
- **`i_fifo_empty` changes mid-frame:** ignored. It is sampled only at the IDLE decision and at frame end.
- **Reset (including mid-frame):**
  - State goes to IDLE.
  - `o_tx` = 1; `o_fifo_stb`, `o_busy`, and `o_byte_done` = 0.
  - A word already popped is discarded and not retransmitted.

## Timing
- All outputs are registered.
- **Reset values:**
  - `o_tx` = 1
  - `o_fifo_stb` = 0
  - `o_busy` = 0
  - `o_byte_done` = 0
- **Start latency:** `o_fifo_stb`, `o_tx` = 0 and `o_busy` = 1 appear in the cycle after the clock edge that samples !empty.
- **Pop timing:**
  - The FIFO advances on the edge that ends the `o_fifo_stb` cycle.
  - `i_fifo_data` is latched on that same earlier edge, so a stale head is never sent.
- **Frame length:** (1 + DATA_WIDTH + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
  - Back-to-back frames have exactly this period.
  - Pop strobes are spaced by the same amount.
- **No double pop:** CLKS_PER_BIT >= 2 guarantees the FIFO's empty flag has updated before the next decision point.
- **`o_busy`:** stays high across back-to-back frames. It falls in the cycle after the final stop cycle when no next word is taken.

## Structure
- **Shared package / include file (`uart_defines`):**
  - parity encodings PARITY_NONE = 0, PARITY_EVEN = 1, PARITY_ODD = 2;
  - FSM state encodings.
- **Sub-module `uart_baud_counter`:**
  - inputs: clear and enable;
  - output: a one-cycle `tick` when the count reaches CLKS_PER_BIT-1.
- The FSM, shift register, bit counter and parity accumulator stay in `fifo_uart_tx`.

## Test plan
All scenarios use CLKS_PER_BIT=4, DATA_WIDTH=8 and drive the real `fifo` with DEPTH=4 unless noted.

1. **Reset:** assert `rst` with no clock running.
   - Required: `o_tx`=1, `o_fifo_stb`=0, `o_busy`=0, `o_byte_done`=0 immediately.
2. **Single word 0xA5:** write 0xA5, PARITY=0, STOP_BITS=1.
   - Exactly one `o_fifo_stb` pulse.
   - `o_tx` bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, 40 cycles total.
   - `o_byte_done` pulses once, on cycle 40.
   - FIFO ends empty.
3. **Back-to-back:** preload 0x00, 0xFF, 0x55.
   - Three pops exactly 40 cycles apart.
   - `o_tx` never idles between frames; `o_busy` stays high for 120 cycles.
4. **Parity:** send 0x07.
   - PARITY=1 (even): parity bit = 1, frame = 44 cycles.
   - PARITY=2 (odd): parity bit = 0.
   - STOP_BITS=2: stop high for 8 cycles.
5. **Enable gating:** drop `i_enable` during bit 3 with 2 words queued.
   - The current frame completes.
   - No `o_fifo_stb` while `i_enable`=0.
   - After re-enable, the next frame starts 1 cycle later.
6. **Async reset mid-frame:** assert `rst` during a DATA bit.
   - `o_tx` goes high without a clock edge and `o_busy`=0.
   - After release, a queued word is popped and sent as a complete frame.
